// File: rtl/ddr_test_seq.sv
// AXI4 master test sequencer: writes a pattern burst, reads it back, and steps
// through a contiguous region, emitting the address/strobe timing for the data generator and checker.
module ddr_test_seq #(
  parameter int AXI_DATA_WIDTH = 256,
  parameter int BURST_LEN      = 16
) (
  input  logic        SysClk,
  input  logic        Reset_N,
  input  logic        TestStart,
  input  logic [31:0] TestBase,
  input  logic [15:0] TestBurstNum,
  output logic        TestBusy,
  output logic        TestDone,
  output logic        RespErr,
  output logic        LenErr,
  output logic        WrStartEn,
  output logic        WriteEn,
  output logic [31:0] WrAddrOut,
  output logic        RdDataEn,
  output logic [31:0] RdAddrOut,
  output logic [31:0] AwAddr,
  output logic [7:0]  AwLen,
  output logic        AwValid,
  input  logic        AwReady,
  output logic        WValid,
  output logic        WLast,
  input  logic        WReady,
  input  logic        BValid,
  input  logic [1:0]  BResp,
  output logic        BReady,
  output logic [31:0] ArAddr,
  output logic [7:0]  ArLen,
  output logic        ArValid,
  input  logic        ArReady,
  input  logic        RValid,
  input  logic        RLast,
  input  logic [1:0]  RResp,
  output logic        RReady,
  output logic [3:0]  DbgState
);

  localparam logic [31:0] BN          = 32'(AXI_DATA_WIDTH / 8);
  localparam logic [31:0] BURST_BYTES = 32'(BURST_LEN * (AXI_DATA_WIDTH / 8));
  localparam logic [7:0]  LEN_M1      = 8'(BURST_LEN - 1);

  // Handshake rule on every AXI channel: a transfer happens in a cycle where
  // valid and ready are both high; a raised valid stays high until that cycle.
  typedef enum logic [3:0] {
    S_IDLE    = 4'd0,
    S_WR_PRE  = 4'd1,
    S_WR_AW   = 4'd2,
    S_WR_DATA = 4'd3,
    S_WR_RESP = 4'd4,
    S_RD_AR   = 4'd5,
    S_RD_DATA = 4'd6,
    S_NEXT    = 4'd7,
    S_DONE    = 4'd8
  } state_t;

  state_t      state, stateNxt;
  logic [31:0] burstAddr;
  logic [31:0] wrAddrReg, wrAddrNxt;
  logic [31:0] rdAddr;
  logic [31:0] beatAddrNxt;
  logic [7:0]  beatCnt;
  logic [15:0] burstCnt;
  logic [15:0] burstNum;
  logic        respErr, lenErr;
  logic        lastBeat;

  assign lastBeat    = (beatCnt == LEN_M1);
  assign beatAddrNxt = burstAddr + (32'(beatCnt) + 32'd1) * BN;

  always_ff @(posedge SysClk or negedge Reset_N) begin
    if (!Reset_N) state <= S_IDLE;
    else          state <= stateNxt;
  end

  always_comb begin
    stateNxt  = state;
    TestDone  = 1'b0;
    WrStartEn = 1'b0;
    AwValid   = 1'b0;
    AwLen     = 8'd0;
    WValid    = 1'b0;
    WLast     = 1'b0;
    BReady    = 1'b0;
    ArValid   = 1'b0;
    ArLen     = 8'd0;
    RReady    = 1'b0;
    wrAddrNxt = wrAddrReg;
    case (state)
      S_IDLE: begin
        if (TestStart) stateNxt = (TestBurstNum == 16'd0) ? S_DONE : S_WR_PRE;
      end
      S_WR_PRE: begin
        WrStartEn = 1'b1;
        wrAddrNxt = burstAddr;
        stateNxt  = S_WR_AW;
      end
      S_WR_AW: begin
        AwValid = 1'b1;
        AwLen   = LEN_M1;
        if (AwReady) stateNxt = S_WR_DATA;
      end
      S_WR_DATA: begin
        WValid = 1'b1;
        WLast  = lastBeat;
        // The generator loads the next beat's data during this handshake.
        if (WReady) begin
          wrAddrNxt = beatAddrNxt;
          if (lastBeat) stateNxt = S_WR_RESP;
        end
      end
      S_WR_RESP: begin
        BReady = 1'b1;
        if (BValid) stateNxt = S_RD_AR;
      end
      S_RD_AR: begin
        ArValid = 1'b1;
        ArLen   = LEN_M1;
        if (ArReady) stateNxt = S_RD_DATA;
      end
      S_RD_DATA: begin
        RReady = 1'b1;
        if (RValid && (RLast || lastBeat)) stateNxt = S_NEXT;
      end
      S_NEXT: begin
        stateNxt = (burstCnt + 16'd1 == burstNum) ? S_DONE : S_WR_PRE;
      end
      S_DONE: begin
        TestDone = 1'b1;
        stateNxt = S_IDLE;
      end
      default: stateNxt = S_IDLE;
    endcase
  end

  always_ff @(posedge SysClk or negedge Reset_N) begin
    if (!Reset_N) begin
      burstAddr <= 32'd0;
      wrAddrReg <= 32'd0;
      rdAddr    <= 32'd0;
      beatCnt   <= 8'd0;
      burstCnt  <= 16'd0;
      burstNum  <= 16'd0;
      respErr   <= 1'b0;
      lenErr    <= 1'b0;
    end else begin
      wrAddrReg <= wrAddrNxt;
      case (state)
        S_IDLE: begin
          if (TestStart) begin
            burstAddr <= TestBase;
            burstCnt  <= 16'd0;
            burstNum  <= TestBurstNum;
            respErr   <= 1'b0;
            lenErr    <= 1'b0;
          end
        end
        S_WR_AW: begin
          if (AwReady) beatCnt <= 8'd0;
        end
        S_WR_DATA: begin
          if (WReady) beatCnt <= beatCnt + 8'd1;
        end
        S_WR_RESP: begin
          if (BValid && (BResp != 2'b00)) respErr <= 1'b1;
        end
        S_RD_AR: begin
          if (ArReady) begin
            beatCnt <= 8'd0;
            rdAddr  <= burstAddr;
          end
        end
        S_RD_DATA: begin
          if (RValid) begin
            rdAddr  <= rdAddr + BN;
            beatCnt <= beatCnt + 8'd1;
            if (RResp != 2'b00) respErr <= 1'b1;
            // RLAST must coincide exactly with the final beat of the burst.
            if (RLast != lastBeat) lenErr <= 1'b1;
          end
        end
        S_NEXT: begin
          burstAddr <= burstAddr + BURST_BYTES;
          burstCnt  <= burstCnt + 16'd1;
        end
        default: ;
      endcase
    end
  end

  assign TestBusy  = (state != S_IDLE);
  assign WriteEn   = WValid & WReady;
  assign RdDataEn  = RValid & RReady;
  assign WrAddrOut = wrAddrNxt;
  assign RdAddrOut = rdAddr;
  assign AwAddr    = burstAddr;
  assign ArAddr    = burstAddr;
  assign RespErr   = respErr;
  assign LenErr    = lenErr;
  assign DbgState  = state;

endmodule

// File: tb/tb_ddr_test_seq.sv
// Directed bench for ddr_test_seq: an AXI slave model, address scoreboards per
// strobe and hand-computed expected burst addresses for BURST_LEN=4, 256-bit data.
`timescale 1ns/1ps
module tb_ddr_test_seq;

  localparam int         DW         = 256;
  localparam int         BL         = 4;
  localparam logic [3:0] ST_IDLE    = 4'd0;
  localparam logic [3:0] ST_WR_DATA = 4'd3;
  localparam logic [3:0] ST_RD_DATA = 4'd6;

  // Clock / reset
  logic SysClk  = 1'b0;
  logic Reset_N = 1'b0;
  always #5 SysClk = ~SysClk;

  logic        TestStart = 1'b0;
  logic [31:0] TestBase = 32'd0;
  logic [15:0] TestBurstNum = 16'd0;
  logic        TestBusy, TestDone, RespErr, LenErr;
  logic        WrStartEn, WriteEn, RdDataEn;
  logic [31:0] WrAddrOut, RdAddrOut, AwAddr, ArAddr;
  logic [7:0]  AwLen, ArLen;
  logic        AwValid, WValid, WLast, BReady, ArValid, RReady;
  logic        AwReady = 1'b0, WReady = 1'b0, BValid = 1'b0, ArReady = 1'b0;
  logic        RValid = 1'b0, RLast = 1'b0;
  logic [1:0]  BResp = 2'd0, RResp = 2'd0;
  logic [3:0]  DbgState;

  ddr_test_seq #(.AXI_DATA_WIDTH(DW), .BURST_LEN(BL)) dut (
    .SysClk(SysClk), .Reset_N(Reset_N), .TestStart(TestStart),
    .TestBase(TestBase), .TestBurstNum(TestBurstNum),
    .TestBusy(TestBusy), .TestDone(TestDone), .RespErr(RespErr), .LenErr(LenErr),
    .WrStartEn(WrStartEn), .WriteEn(WriteEn), .WrAddrOut(WrAddrOut),
    .RdDataEn(RdDataEn), .RdAddrOut(RdAddrOut),
    .AwAddr(AwAddr), .AwLen(AwLen), .AwValid(AwValid), .AwReady(AwReady),
    .WValid(WValid), .WLast(WLast), .WReady(WReady),
    .BValid(BValid), .BResp(BResp), .BReady(BReady),
    .ArAddr(ArAddr), .ArLen(ArLen), .ArValid(ArValid), .ArReady(ArReady),
    .RValid(RValid), .RLast(RLast), .RResp(RResp), .RReady(RReady),
    .DbgState(DbgState)
  );

  // Scoreboard
  int nTests = 0;
  int nFail  = 0;
  logic [31:0] expPreQ[$], expAwQ[$], expWrQ[$], expArQ[$], expRdQ[$];
  bit stallMode = 0, bErrFirst = 0, earlyLast = 0;
  int rdBeat = 0, wrBeat = 0, bCnt = 0, wrCnt = 0, rdCnt = 0;
  int doneCnt = 0, dataCycles = 0, stableViol = 0;
  bit busyAtDone = 0, prevWaitW = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    nTests++;
    if (got !== exp) begin
      nFail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clearSb();
    expPreQ.delete(); expAwQ.delete(); expWrQ.delete(); expArQ.delete(); expRdQ.delete();
    rdBeat = 0; wrBeat = 0; bCnt = 0; wrCnt = 0; rdCnt = 0;
    doneCnt = 0; dataCycles = 0; stableViol = 0; busyAtDone = 0; prevWaitW = 0;
  endtask

  task automatic expBurst(input logic [31:0] b, input int nRd);
    expPreQ.push_back(b);
    expAwQ.push_back(b);
    expArQ.push_back(b);
    for (int i = 0; i < BL; i++) expWrQ.push_back(b + 32'((i + 1) * 32));
    for (int i = 0; i < nRd; i++) expRdQ.push_back(b + 32'(i * 32));
  endtask

  // Slave model and monitor: drive at negedge, observe 1 ns later
  initial begin
    forever begin
      @(negedge SysClk);
      AwReady = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
      ArReady = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
      WReady  = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
      RValid  = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
      BValid  = stallMode ? 1'($urandom_range(0, 1)) : 1'b1;
      BResp   = (bErrFirst && bCnt == 0) ? 2'd2 : 2'd0;
      RResp   = 2'd0;
      RLast   = (rdBeat == (earlyLast ? 1 : BL - 1));
      #1;
      if (!Reset_N) continue;
      if (prevWaitW && !WValid) stableViol++;
      prevWaitW = WValid && !WReady;
      if (DbgState == ST_WR_DATA || DbgState == ST_RD_DATA) dataCycles++;
      if (WrStartEn) begin
        chk("pre_q_level", 32'(expPreQ.size() != 0), 32'd1);
        if (expPreQ.size() != 0) chk("pre_addr", WrAddrOut, expPreQ.pop_front());
      end
      if (AwValid && AwReady) begin
        chk("aw_len", 32'(AwLen), 32'(BL - 1));
        chk("aw_q_level", 32'(expAwQ.size() != 0), 32'd1);
        if (expAwQ.size() != 0) chk("aw_addr", AwAddr, expAwQ.pop_front());
      end
      if (WriteEn) begin
        chk("wlast", 32'(WLast), 32'(wrBeat == BL - 1));
        chk("wr_q_level", 32'(expWrQ.size() != 0), 32'd1);
        if (expWrQ.size() != 0) chk("wr_addr", WrAddrOut, expWrQ.pop_front());
        wrBeat = (wrBeat == BL - 1) ? 0 : wrBeat + 1;
        wrCnt++;
      end
      if (BValid && BReady) bCnt++;
      if (ArValid && ArReady) begin
        chk("ar_len", 32'(ArLen), 32'(BL - 1));
        chk("ar_q_level", 32'(expArQ.size() != 0), 32'd1);
        if (expArQ.size() != 0) chk("ar_addr", ArAddr, expArQ.pop_front());
      end
      if (RdDataEn) begin
        chk("rd_q_level", 32'(expRdQ.size() != 0), 32'd1);
        if (expRdQ.size() != 0) chk("rd_addr", RdAddrOut, expRdQ.pop_front());
        rdBeat = RLast ? 0 : rdBeat + 1;
        rdCnt++;
      end
      if (TestDone) begin
        doneCnt++;
        busyAtDone = TestBusy;
      end
    end
  end

  // Driver tasks
  task automatic startTest(input logic [31:0] base, input logic [15:0] num);
    @(negedge SysClk);
    TestBase = base; TestBurstNum = num; TestStart = 1'b1;
    @(negedge SysClk);
    TestStart = 1'b0;
    #2;
    chk("busy_after_start", 32'(TestBusy), 32'd1);
    chk("resp_err_cleared", 32'(RespErr), 32'd0);
    chk("len_err_cleared", 32'(LenErr), 32'd0);
  endtask

  task automatic runTest(input logic [31:0] base, input logic [15:0] num,
                         input int expWr, input int expRd,
                         input logic expResp, input logic expLen, input bit noBubbles);
    int n;
    startTest(base, num);
    n = 0;
    while (doneCnt == 0 && n < 2000) begin
      @(negedge SysClk);
      n++;
    end
    chk("done_seen", 32'(doneCnt != 0), 32'd1);
    repeat (3) @(negedge SysClk);
    #2;
    chk("done_pulses", 32'(doneCnt), 32'd1);
    chk("busy_at_done", 32'(busyAtDone), 32'd1);
    chk("busy_after_done", 32'(TestBusy), 32'd0);
    chk("state_idle", 32'(DbgState), 32'(ST_IDLE));
    chk("wr_count", 32'(wrCnt), 32'(expWr));
    chk("rd_count", 32'(rdCnt), 32'(expRd));
    chk("resp_err", 32'(RespErr), 32'(expResp));
    chk("len_err", 32'(LenErr), 32'(expLen));
    chk("wvalid_stable", 32'(stableViol), 32'd0);
    chk("sb_left", 32'(expPreQ.size() + expAwQ.size() + expWrQ.size()
                       + expArQ.size() + expRdQ.size()), 32'd0);
    if (noBubbles) chk("data_cycles", 32'(dataCycles), 32'(wrCnt + rdCnt));
  endtask

  initial begin
    int n;
    #12;
    chk("rst_valids", {28'd0, AwValid, WValid, ArValid, WLast}, 32'd0);
    chk("rst_readies", {29'd0, BReady, RReady, WrStartEn}, 32'd0);
    chk("rst_status", {28'd0, TestBusy, TestDone, RespErr, LenErr}, 32'd0);
    chk("rst_wr_addr", WrAddrOut, 32'd0);
    chk("rst_rd_addr", RdAddrOut, 32'd0);
    chk("rst_aw_addr", AwAddr, 32'd0);
    chk("rst_state", 32'(DbgState), 32'(ST_IDLE));
    @(negedge SysClk);
    Reset_N = 1'b1;
    repeat (2) @(negedge SysClk);

    // Single burst, zero-wait slave
    clearSb(); expBurst(32'h0000_1000, 4);
    runTest(32'h0000_1000, 16'd1, 4, 4, 1'b0, 1'b0, 1);

    // Three bursts: 0x1000, 0x1080, 0x1100
    clearSb();
    expBurst(32'h0000_1000, 4); expBurst(32'h0000_1080, 4); expBurst(32'h0000_1100, 4);
    runTest(32'h0000_1000, 16'd3, 12, 12, 1'b0, 1'b0, 1);

    // Random stalls on every slave-controlled signal
    clearSb(); stallMode = 1;
    expBurst(32'h0000_2000, 4); expBurst(32'h0000_2080, 4);
    runTest(32'h0000_2000, 16'd2, 8, 8, 1'b0, 1'b0, 0);
    stallMode = 0;

    // Error response on the first write burst stays sticky
    clearSb(); bErrFirst = 1;
    expBurst(32'h0000_3000, 4); expBurst(32'h0000_3080, 4);
    runTest(32'h0000_3000, 16'd2, 8, 8, 1'b1, 1'b0, 1);
    bErrFirst = 0;

    // Next start clears the flag
    clearSb(); expBurst(32'h0000_1000, 4);
    runTest(32'h0000_1000, 16'd1, 4, 4, 1'b0, 1'b0, 1);

    // RLAST on beat 2 of 4
    clearSb(); earlyLast = 1; expBurst(32'h0000_4000, 2);
    runTest(32'h0000_4000, 16'd1, 4, 2, 1'b0, 1'b1, 1);
    earlyLast = 0;

    // Address wrap: second burst at 0x40
    clearSb(); expBurst(32'hFFFF_FFC0, 4); expBurst(32'h0000_0040, 4);
    runTest(32'hFFFF_FFC0, 16'd2, 8, 8, 1'b0, 1'b0, 1);

    // Zero bursts: done with no traffic
    clearSb();
    runTest(32'h0000_6000, 16'd0, 0, 0, 1'b0, 1'b0, 1);

    // Reset during write data phase
    clearSb(); expBurst(32'h0000_5000, 4);
    startTest(32'h0000_5000, 16'd1);
    n = 0;
    while (DbgState != ST_WR_DATA && n < 100) begin
      @(negedge SysClk);
      n++;
    end
    chk("reached_wr_data", 32'(DbgState), 32'(ST_WR_DATA));
    #2 Reset_N = 1'b0;
    #1;
    chk("rst_mid_wvalid", 32'(WValid), 32'd0);
    chk("rst_mid_state", 32'(DbgState), 32'(ST_IDLE));
    chk("rst_mid_busy", 32'(TestBusy), 32'd0);
    chk("rst_mid_wr_addr", WrAddrOut, 32'd0);
    @(negedge SysClk);
    Reset_N = 1'b1;
    clearSb(); expBurst(32'h0000_1000, 4);
    runTest(32'h0000_1000, 16'd1, 4, 4, 1'b0, 1'b0, 1);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule

// File: doc/ddr_test_seq.md
Name: ddr_test_seq

Overview:
- AXI4 master test sequencer: the initiator driving DdrWrDataGen and DdrRdDataChk.
- Per test it writes a pattern burst to DDR, then reads the same burst back, and repeats this over a contiguous region.
- Outputs address/strobe timing that DdrWrDataGen and DdrRdDataChk consume; the AXI controller is its slave.
- WDATA comes from DdrWrDataGen.DdrWrData and RDATA goes to DdrRdDataChk.DdrRdData outside this block; data buses do not pass through it.

Parameters:
AXI_DATA_WIDTH, 256, AXI data width in bits; byte step per beat BN = AXI_DATA_WIDTH/8.
BURST_LEN, 16, beats per burst, legal 1..256; AWLEN = ARLEN = BURST_LEN-1.

Ports:
SysClk  in  1  system clock; all logic on rising edge.
Reset_N  in  1  asynchronous active-low reset.
TestStart  in  1  one-cycle start pulse; honoured in IDLE only.
TestBase  in  32  byte start address, sampled on TestStart.
TestBurstNum  in  16  number of write+read burst pairs, sampled on TestStart.
TestBusy  out  1  high from the cycle after an accepted TestStart until DONE exits.
TestDone  out  1  one-cycle pulse in DONE.
RespErr  out  1  sticky; set on BRESP≠0 or RRESP≠0; cleared on accepted TestStart.
LenErr  out  1  sticky; set on RLAST mismatch; cleared on accepted TestStart.
WrStartEn  out  1  to DdrWrDataGen: preload strobe.
WriteEn  out  1  to DdrWrDataGen: WVALID & WREADY.
WrAddrOut  out  32  to DdrWrDataGen.WrAddrIn.
RdDataEn  out  1  to DdrRdDataChk: RVALID & RREADY.
RdAddrOut  out  32  to DdrRdDataChk.RdAddrIn.
AwAddr/AwLen/AwValid/AwReady  out/out/out/in  32/8/1/1  AXI write address channel.
WValid/WLast/WReady  out/out/in  1/1/1  AXI write data channel.
BValid/BResp/BReady  in/in/out  1/2/1  AXI write response channel.
ArAddr/ArLen/ArValid/ArReady  out/out/out/in  32/8/1/1  AXI read address channel.
RValid/RLast/RResp/RReady  in/in/in/out  1/1/2/1  AXI read data channel.

Behaviour:
- Reset: state IDLE; all outputs 0, including valids, readies, strobes, error flags and addresses.
- Reset mid-burst aborts immediately with valids dropped. This is accepted only under reset.
- Registers: BurstAddr (32b), BeatCnt (8b), BurstCnt (16b). AwAddr = ArAddr = BurstAddr.
- IDLE: TestStart latches BurstAddr=TestBase, BurstCnt=0, and clears both error flags.
  - If TestBurstNum==0, go to DONE with no AXI traffic.
  - Otherwise go to WR_PRE.
- WR_PRE (1 cycle): WrStartEn=1, WrAddrOut=BurstAddr, so the first beat's data is registered in the generator before WValid rises. Then go to WR_AW.
- WR_AW: AwValid=1 held until AwReady. Then go to WR_DATA with BeatCnt=0.
- WR_DATA: WValid=1; WLast=(BeatCnt==BURST_LEN-1); WriteEn=WValid&WReady.
  - On each handshake, WrAddrOut <= BurstAddr+(BeatCnt+1)*BN, i.e. the next beat address, presented the same cycle WriteEn is high. BeatCnt++.
  - After the last handshake go to WR_RESP. WValid never drops without a handshake.
- WR_RESP: BReady=1. On BValid, set RespErr if BResp≠0, then go to RD_AR.
- RD_AR: ArValid=1 until ArReady. Then go to RD_DATA with BeatCnt=0 and RdAddrOut=BurstAddr.
- RD_DATA: RReady=1; RdDataEn=RValid&RReady (combinational). RdAddrOut holds the current beat's address during the handshake cycle.
  - On each handshake: RdAddrOut += BN; BeatCnt++; set RespErr if RResp≠0.
  - LenErr is set if RLAST=1 with BeatCnt≠BURST_LEN-1, or RLAST=0 with BeatCnt==BURST_LEN-1.
  - Exit to NEXT on RLAST or on beat BURST_LEN, whichever comes first.
- NEXT (1 cycle): BurstAddr += BURST_LEN*BN, modulo 2^32 (wraps silently); BurstCnt++.
  - If BurstCnt+1==TestBurstNum, go to DONE; else go to WR_PRE.
- DONE (1 cycle): TestDone=1, then go to IDLE. TestBusy=0 in IDLE.
- TestStart outside IDLE is ignored.
- Ready and valid may be asserted simultaneously in any cycle; zero-wait slaves must give back-to-back beats with no bubbles.

Test Plan:
- BURST_LEN=4, TestBase=0x1000, TestBurstNum=1, zero-wait slave -> AwAddr=0x1000, AwLen=3; WrAddrOut sequence 0x1000,0x1020,0x1040,0x1060,0x1080; 4 RdDataEn pulses with RdAddrOut 0x1000..0x1060; TestDone one pulse; DdrRdError never asserted.
- TestBurstNum=3 -> bursts at 0x1000, 0x1080, 0x1100; exactly 12 WriteEn and 12 RdDataEn; TestBusy drops with TestDone.
- Random WReady/RValid stalls (50%) -> WValid held stable; WriteEn count=4 per burst; checker reports no error.
- BResp=2 on burst 0 -> RespErr=1 sticky through TestDone; next TestStart clears it.
- RLAST on beat 2 of 4 -> LenErr=1; FSM enters NEXT.
- TestBase=0xFFFFFFC0, TestBurstNum=2 -> second AwAddr=0x00000040. Reset_N low during WR_DATA -> WValid=0 asynchronously; FSM in IDLE.
